qpsk_link_sched: RTL and testbench

- Timing and phase controller for the QPSK link. Issues the symbol-rate enable that paces PRBS/TX and sets the RX downsampling phase.
- Sweeps all OS downsampling phases while counting symbol errors from the BER comparator, then locks onto the phase with the fewest errors.
- Monitors the locked link and re-sweeps when errors exceed a threshold.
- Sits between the board switches and the PRBS/TX/RX/BER datapath inside the top level.

---
 rtl/qpsk_link_sched.sv | 169 ++++++++++++++++
 tb/tb_qpsk_link_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_link_sched.sv
// QPSK link timing/phase controller: symbol enable, RX phase sweep with error windows, lock and re-sweep.
// Optional per-link statistics counters are built when QPSK_LINK_SCHED_STATS_EN is defined.
module qpsk_link_sched #(
    parameter int unsigned OS       = 4,
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned LOCK_THR = 8,
    parameter int unsigned ERR_W    = 16
) (
    input  logic                    CLK100MHZ,
    input  logic                    rst,
    input  logic [1:0]              i_switch,
    input  logic                    i_err_valid,
    input  logic                    i_err,
    output logic                    o_en_sym,
    output logic [$clog2(OS)-1:0]   o_phase,
    output logic                    o_lock,
    output logic [$clog2(OS)-1:0]   o_best_phase,
    output logic [ERR_W-1:0]        o_err_win
`ifdef QPSK_LINK_SCHED_STATS_EN
    ,
    output logic [31:0]             o_sym_total,
    output logic [31:0]             o_err_total
`endif
);

    localparam int unsigned PW = $clog2(OS);
    localparam int unsigned SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int unsigned WW = WIN_LOG2;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_run;
    logic [PW-1:0]    r_cnt;
    logic [SW-1:0]    r_settle;
    logic [WW-1:0]    r_win_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] r_min;

    logic             w_slot;
    logic             w_win_end;
    logic             w_better;
    logic [ERR_W-1:0] w_err_next;

    // A slot is any comparator pulse while the link is enabled and out of IDLE
    assign w_slot     = i_err_valid && (r_state != S_IDLE) && i_switch[1];
    assign w_err_next = (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + ERR_W'(i_err);
    assign w_win_end  = w_slot && (r_settle == SW'(0)) && (r_win_cnt == {WW{1'b1}});
    assign w_better   = w_err_next < r_min;

    // Symbol enable: r_run delays the count start so the first pulse lands OS clocks after enable
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            o_en_sym <= 1'b0;
        end else begin
            r_run <= i_switch[0];
            if (!i_switch[0]) begin
                r_cnt    <= '0;
                o_en_sym <= 1'b0;
            end else if (r_run) begin
                r_cnt    <= (r_cnt == PW'(OS - 1)) ? '0 : r_cnt + PW'(1);
                o_en_sym <= (r_cnt == PW'(OS - 2));
            end else begin
                o_en_sym <= 1'b0;
            end
        end
    end

    // Sweep/lock controller with registered outputs
    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_settle     <= SW'(SETTLE);
            r_win_cnt    <= '0;
            r_err_cnt    <= '0;
            r_min        <= '1;
            o_phase      <= '0;
            o_lock       <= 1'b0;
            o_best_phase <= '0;
            o_err_win    <= '0;
`ifdef QPSK_LINK_SCHED_STATS_EN
            o_sym_total  <= '0;
            o_err_total  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_switch[1]) begin
                        r_state   <= S_SWEEP;
                        o_phase   <= '0;
                        o_lock    <= 1'b0;
                        r_min     <= '1;
                        r_settle  <= SW'(SETTLE);
                        r_win_cnt <= '0;
                        r_err_cnt <= '0;
`ifdef QPSK_LINK_SCHED_STATS_EN
                        o_sym_total <= '0;
                        o_err_total <= '0;
`endif
                    end
                end
                default: begin
                    if (!i_switch[1]) begin
                        r_state   <= S_IDLE;
                        o_lock    <= 1'b0;
                        r_settle  <= SW'(SETTLE);
                        r_win_cnt <= '0;
                        r_err_cnt <= '0;
                    end else begin
`ifdef QPSK_LINK_SCHED_STATS_EN
                        if ((r_state == S_LOCKED) && i_err_valid) begin
                            o_sym_total <= o_sym_total + 32'd1;
                            o_err_total <= o_err_total + 32'(i_err);
                        end
`endif
                        if (w_slot) begin
                            if (r_settle != SW'(0)) begin
                                r_settle <= r_settle - SW'(1);
                            end else if (!w_win_end) begin
                                r_win_cnt <= r_win_cnt + WW'(1);
                                r_err_cnt <= w_err_next;
                            end else begin
                                r_win_cnt <= '0;
                                r_err_cnt <= '0;
                                o_err_win <= w_err_next;
                                if (r_state == S_SWEEP) begin
                                    r_settle <= SW'(SETTLE);
                                    if (w_better) begin
                                        r_min        <= w_err_next;
                                        o_best_phase <= o_phase;
                                    end
                                    if (o_phase != PW'(OS - 1)) begin
                                        o_phase <= o_phase + PW'(1);
                                    end else begin
                                        // Last phase: jump straight to the winner, which may be this phase
                                        if (!w_better) begin
                                            o_phase <= o_best_phase;
                                        end
                                        r_state <= S_LOCKED;
                                        o_lock  <= 1'b1;
                                    end
                                end else if (w_err_next > ERR_W'(LOCK_THR)) begin
                                    r_state  <= S_SWEEP;
                                    o_lock   <= 1'b0;
                                    o_phase  <= '0;
                                    r_min    <= '1;
                                    r_settle <= SW'(SETTLE);
`ifdef QPSK_LINK_SCHED_STATS_EN
                                    o_sym_total <= '0;
                                    o_err_total <= '0;
`endif
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_link_sched.sv
// Self-checking bench for qpsk_link_sched: window results are queued as stimulus is sent and checked on window close.
module tb_qpsk_link_sched;

    typedef struct packed {
        logic [15:0] err_win;
        logic [1:0]  phase;
        logic        lock;
        logic [1:0]  best;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  i_switch;
    logic        i_err_valid;
    logic        i_err;
    logic        o_en_sym;
    logic [1:0]  o_phase;
    logic        o_lock;
    logic [1:0]  o_best_phase;
    logic [15:0] o_err_win;
`ifdef QPSK_LINK_SCHED_STATS_EN
    logic [31:0] o_sym_total;
    logic [31:0] o_err_total;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    qpsk_link_sched #(
        .OS(4), .WIN_LOG2(4), .SETTLE(2), .LOCK_THR(3), .ERR_W(16)
    ) dut (
        .CLK100MHZ   (clk),
        .rst         (rst_n),
        .i_switch    (i_switch),
        .i_err_valid (i_err_valid),
        .i_err       (i_err),
        .o_en_sym    (o_en_sym),
        .o_phase     (o_phase),
        .o_lock      (o_lock),
        .o_best_phase(o_best_phase),
        .o_err_win   (o_err_win)
`ifdef QPSK_LINK_SCHED_STATS_EN
        ,
        .o_sym_total (o_sym_total),
        .o_err_total (o_err_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input int ew, input int ph, input int lk, input int bp);
        exp_t e;
        e.err_win = 16'(ew);
        e.phase   = 2'(ph);
        e.lock    = 1'(lk);
        e.best    = 2'(bp);
        return e;
    endfunction

    // Drive one comparator pulse; returns 1 time unit after the edge that samples it
    task automatic pulse_on(input logic err);
        @(negedge clk);
        i_err_valid = 1'b1;
        i_err       = err;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_off();
        @(negedge clk);
        i_err_valid = 1'b0;
        i_err       = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Settle slots then a 16-slot window; stops just after the closing edge with the pulse still high
    task automatic send_window(input int n_settle, input logic settle_err, input int n_err);
        for (int i = 0; i < n_settle; i++) begin
            pulse_on(settle_err);
            pulse_off();
        end
        for (int i = 0; i < 16; i++) begin
            pulse_on(i < n_err);
            if (i < 15) pulse_off();
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst_n = 1'b0; i_switch = 2'b01; i_err_valid = 1'b0; i_err = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if ({o_en_sym, o_phase, o_lock, o_best_phase, o_err_win} !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_outputs got en=%0b ph=%0d lk=%0b bp=%0d ew=%0d exp all 0",
                     o_en_sym, o_phase, o_lock, o_best_phase, o_err_win);
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o_en_sym !== ((k % 4) == 0)) begin
                failures++;
                $display("FAIL en_sym_edge%0d got %0b exp %0b", k, o_en_sym, (k % 4) == 0);
            end
        end
        @(negedge clk);
        i_switch = 2'b00;
        for (int k = 12; k <= 20; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o_en_sym !== 1'b0) begin
                failures++;
                $display("FAIL en_sym_off_edge%0d got %0b exp 0", k, o_en_sym);
            end
        end
    endtask

    task automatic test_clean_sweep();
        exp_t g;
        exp_t act;
        int   n_err[4];
        n_err = '{16, 16, 0, 16};
        @(negedge clk);
        i_switch = 2'b11;
        sb_q.push_back(mk(16, 1, 0, 0));
        sb_q.push_back(mk(16, 2, 0, 0));
        sb_q.push_back(mk(0, 3, 0, 2));
        sb_q.push_back(mk(16, 2, 1, 2));
        for (int p = 0; p < 4; p++) begin
            send_window(2, (p != 2), n_err[p]);
            g   = sb_q.pop_front();
            act = {o_err_win, o_phase, o_lock, o_best_phase};
            checks++;
            if (act !== g) begin
                failures++;
                $display("FAIL clean_sweep_p%0d got ew=%0d ph=%0d lk=%0b bp=%0d exp ew=%0d ph=%0d lk=%0b bp=%0d",
                         p, act.err_win, act.phase, act.lock, act.best, g.err_win, g.phase, g.lock, g.best);
            end
            pulse_off();
        end
    endtask

    task automatic test_tie_break();
        exp_t g;
        exp_t act;
        int   n_err[4];
        n_err = '{5, 0, 5, 0};
        @(negedge clk);
        i_switch = 2'b01;
        repeat (2) @(negedge clk);
        i_switch = 2'b11;
        sb_q.push_back(mk(5, 1, 0, 0));
        sb_q.push_back(mk(0, 2, 0, 1));
        sb_q.push_back(mk(5, 3, 0, 1));
        sb_q.push_back(mk(0, 1, 1, 1));
        for (int p = 0; p < 4; p++) begin
            send_window(2, 1'b1, n_err[p]);
            g   = sb_q.pop_front();
            act = {o_err_win, o_phase, o_lock, o_best_phase};
            checks++;
            if (act !== g) begin
                failures++;
                $display("FAIL tie_break_p%0d got ew=%0d ph=%0d lk=%0b bp=%0d exp ew=%0d ph=%0d lk=%0b bp=%0d",
                         p, act.err_win, act.phase, act.lock, act.best, g.err_win, g.phase, g.lock, g.best);
            end
            pulse_off();
        end
    endtask

    task automatic test_loss_of_lock();
        exp_t g;
        exp_t act;
        sb_q.push_back(mk(3, 1, 1, 1));
        sb_q.push_back(mk(4, 0, 0, 1));
        for (int w = 0; w < 2; w++) begin
            if (w == 1) begin
                checks++;
                if (o_lock !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_before_bad_window got %0b exp 1", o_lock);
                end
            end
            send_window((w == 0) ? 2 : 0, 1'b1, 3 + w);
            g   = sb_q.pop_front();
            act = {o_err_win, o_phase, o_lock, o_best_phase};
            checks++;
            if (act !== g) begin
                failures++;
                $display("FAIL lock_window%0d got ew=%0d ph=%0d lk=%0b bp=%0d exp ew=%0d ph=%0d lk=%0b bp=%0d",
                         w, act.err_win, act.phase, act.lock, act.best, g.err_win, g.phase, g.lock, g.best);
            end
            pulse_off();
        end
    endtask

    task automatic test_disable_and_reset();
        exp_t g;
        exp_t act;
        int   n_err[4];
        n_err = '{7, 7, 2, 1};
        sb_q.push_back(mk(7, 1, 0, 0));
        sb_q.push_back(mk(7, 2, 0, 0));
        for (int p = 0; p < 4; p++) begin
            if (p == 2) begin
                // Partial window at phase 2, then drop the RX enable
                for (int i = 0; i < 7; i++) begin
                    pulse_on(1'b1);
                    pulse_off();
                end
                @(negedge clk);
                i_switch = 2'b01;
                @(posedge clk); #1;
                checks++;
                if ({o_lock, o_phase, o_best_phase, o_err_win} !== {1'b0, 2'd2, 2'd0, 16'd7}) begin
                    failures++;
                    $display("FAIL disable_hold got lk=%0b ph=%0d bp=%0d ew=%0d exp lk=0 ph=2 bp=0 ew=7",
                             o_lock, o_phase, o_best_phase, o_err_win);
                end
                for (int i = 0; i < 3; i++) begin
                    pulse_on(1'b1);
                    pulse_off();
                end
                @(negedge clk);
                i_switch = 2'b11;
                @(posedge clk); #1;
                checks++;
                if ({o_lock, o_phase} !== {1'b0, 2'd0}) begin
                    failures++;
                    $display("FAIL reenable_phase got lk=%0b ph=%0d exp lk=0 ph=0", o_lock, o_phase);
                end
                sb_q.push_back(mk(2, 1, 0, 0));
                sb_q.push_back(mk(1, 2, 0, 1));
            end
            send_window(2, 1'b1, n_err[p]);
            g   = sb_q.pop_front();
            act = {o_err_win, o_phase, o_lock, o_best_phase};
            checks++;
            if (act !== g) begin
                failures++;
                $display("FAIL disable_w%0d got ew=%0d ph=%0d lk=%0b bp=%0d exp ew=%0d ph=%0d lk=%0b bp=%0d",
                         p, act.err_win, act.phase, act.lock, act.best, g.err_win, g.phase, g.lock, g.best);
            end
            pulse_off();
        end
        for (int i = 0; i < 5; i++) begin
            pulse_on(1'b1);
            pulse_off();
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_en_sym, o_phase, o_lock, o_best_phase, o_err_win} !== '0) begin
            failures++;
            $display("FAIL async_reset got en=%0b ph=%0d lk=%0b bp=%0d ew=%0d exp all 0",
                     o_en_sym, o_phase, o_lock, o_best_phase, o_err_win);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef QPSK_LINK_SCHED_STATS_EN
    task automatic test_stats();
        exp_t g;
        exp_t act;
        sb_q.push_back(mk(0, 1, 0, 0));
        sb_q.push_back(mk(0, 2, 0, 0));
        sb_q.push_back(mk(0, 3, 0, 0));
        sb_q.push_back(mk(0, 0, 1, 0));
        for (int p = 0; p < 4; p++) begin
            send_window(2, 1'b0, 0);
            g   = sb_q.pop_front();
            act = {o_err_win, o_phase, o_lock, o_best_phase};
            checks++;
            if (act !== g) begin
                failures++;
                $display("FAIL stats_sweep_p%0d got ew=%0d ph=%0d lk=%0b bp=%0d exp ew=%0d ph=%0d lk=%0b bp=%0d",
                         p, act.err_win, act.phase, act.lock, act.best, g.err_win, g.phase, g.lock, g.best);
            end
            pulse_off();
        end
        for (int i = 0; i < 40; i++) begin
            pulse_on((i == 5) || (i == 20) || (i == 39));
            pulse_off();
        end
        checks++;
        if ({o_sym_total, o_err_total, o_lock} !== {32'd40, 32'd3, 1'b1}) begin
            failures++;
            $display("FAIL stats_totals got sym=%0d err=%0d lk=%0b exp sym=40 err=3 lk=1",
                     o_sym_total, o_err_total, o_lock);
        end
        for (int i = 0; i < 10; i++) begin
            pulse_on(i < 4);
            pulse_off();
        end
        checks++;
        if ({o_sym_total, o_err_total, o_lock} !== {32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL stats_cleared got sym=%0d err=%0d lk=%0b exp sym=0 err=0 lk=0",
                     o_sym_total, o_err_total, o_lock);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_enable();
        test_clean_sweep();
        test_tie_break();
        test_loss_of_lock();
        test_disable_and_reset();
`ifdef QPSK_LINK_SCHED_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
